// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - camera byte-stream capture: sync, pixel pairing, luma quantisation, framing checks
module camera_capture #(
    parameter int OUT_W    = 3,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int MODE     = 0
) (
    input  logic             clk_25,
    input  logic             reset,
    input  logic             capture_en,
    input  logic             err_clr,
    input  logic [7:0]       data_in,
    input  logic             h_ref,
    input  logic             v_sync,
    output logic             pix_valid,
    output logic [OUT_W-1:0] pix_data,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             line_done,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic             err_short,
    output logic             err_long
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_LINE  = 2'd2;

    // Counters are one bit wider than the ports so they can hold H_ACTIVE / V_ACTIVE themselves.
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_ACTIVE);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_ACTIVE);
    localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

    logic [7:0] s1_data_q, data_q;
    logic       s1_hr_q, hr_q, hr_prev_q;
    logic       s1_vs_q, vs_q, vs_prev_q;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            s1_data_q <= '0;
            s1_hr_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            data_q    <= '0;
            hr_q      <= 1'b0;
            vs_q      <= 1'b0;
            hr_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            s1_data_q <= data_in;
            s1_hr_q   <= h_ref;
            s1_vs_q   <= v_sync;
            data_q    <= s1_data_q;
            hr_q      <= s1_hr_q;
            vs_q      <= s1_vs_q;
            hr_prev_q <= hr_q;
            vs_prev_q <= vs_q;
        end
    end

    logic hr_rise, hr_fall, vs_rise, vs_fall;
    assign hr_rise = hr_q & ~hr_prev_q;
    assign hr_fall = ~hr_q & hr_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;
    assign vs_fall = ~vs_q & vs_prev_q;

    logic [1:0]       state_q, state_d;
    logic             phase_q, phase_d;
    logic [7:0]       b0_q, b0_d;
    logic [X_W:0]     x_q, x_d;
    logic [Y_W:0]     y_q, y_d;
    logic             pend_valid_q, pend_valid_d;
    logic [OUT_W-1:0] pend_data_q, pend_data_d;
    logic [X_W-1:0]   pend_x_q, pend_x_d;
    logic [Y_W-1:0]   pend_y_q, pend_y_d;
    logic             line_done_q, line_done_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             pix_valid_q;
    logic [OUT_W-1:0] pix_data_q;
    logic [X_W-1:0]   pix_x_q;
    logic [Y_W-1:0]   pix_y_q;

    logic [5:0] green;
    logic [7:0] luma;
    logic       set_short, set_long;

    assign green = {b0_q[2:0], data_q[7:5]};
    assign luma  = (MODE == 1) ? {green, 2'b00} : b0_q;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        b0_d          = b0_q;
        x_d           = x_q;
        y_d           = y_q;
        pend_valid_d  = 1'b0;
        pend_data_d   = OUT_W'(luma >> (8 - OUT_W));
        pend_x_d      = x_q[X_W-1:0];
        pend_y_d      = y_q[Y_W-1:0];
        line_done_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        set_short     = 1'b0;
        set_long      = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (vs_fall && capture_en) begin
                    state_d       = S_FRAME;
                    frame_start_d = 1'b1;
                    y_d           = '0;
                end
            end
            S_FRAME: begin
                if (vs_rise) begin
                    state_d     = S_WAIT;
                    frame_end_d = 1'b1;
                    x_d         = '0;
                    y_d         = '0;
                    phase_d     = 1'b0;
                end else if (hr_rise) begin
                    // The first byte of the line arrives together with the rising edge.
                    state_d = S_LINE;
                    x_d     = '0;
                    b0_d    = data_q;
                    phase_d = 1'b1;
                end
            end
            S_LINE: begin
                if (vs_rise) begin
                    state_d     = S_WAIT;
                    frame_end_d = 1'b1;
                    x_d         = '0;
                    y_d         = '0;
                    phase_d     = 1'b0;
                end else if (hr_fall) begin
                    state_d = S_FRAME;
                    phase_d = 1'b0;
                    x_d     = '0;
                    set_short = (x_q < H_LIM);
                    if (y_q < V_LIM) begin
                        line_done_d = 1'b1;
                        y_d         = y_q + Y_ONE;
                    end else begin
                        set_long = 1'b1;
                    end
                end else if (hr_q) begin
                    if (!phase_q) begin
                        b0_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // x counts formed pixels, saturating at H_ACTIVE, even on a dropped line.
                        if (x_q < H_LIM) begin
                            x_d          = x_q + X_ONE;
                            pend_valid_d = (y_q < V_LIM);
                        end else begin
                            set_long = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_WAIT;
        endcase
        err_short_d = (err_short_q & ~err_clr) | set_short;
        err_long_d  = (err_long_q & ~err_clr) | set_long;
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q       <= S_WAIT;
            phase_q       <= 1'b0;
            b0_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= '0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            line_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            b0_q          <= b0_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pend_valid_q  <= pend_valid_d;
            pend_data_q   <= pend_data_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            line_done_q   <= line_done_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            pix_valid_q   <= pend_valid_q;
            pix_data_q    <= pend_data_q;
            pix_x_q       <= pend_x_q;
            pix_y_q       <= pend_y_q;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_done   = line_done_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = (state_q == S_FRAME) || (state_q == S_LINE);
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;

endmodule
